// File: rtl/hazard_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hazard_control                                               |
// | Description : Pipeline stall/flush controller for load-use hazards, taken  |
// |               branches, data-memory waits and halt drain.                  |
// |               Optional macro HAZARD_STATS_EN adds stall/flush counters.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module hazard_control #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read_dx,
   input  logic [3:0]  rd_dx,
   input  logic [3:0]  rs_fd,
   input  logic [3:0]  rt_fd,
   input  logic        uses_rt_fd,
   input  logic        branch_taken_d,
   input  logic        mem_req_xm,
   input  logic        mem_ready,
   input  logic        hlt_mw,
   output logic        en_pc,
   output logic        en_fd,
   output logic        en_dx,
   output logic        en_xm,
   output logic        en_mw,
   output logic        flush_fd,
   output logic        flush_dx,
`ifdef HAZARD_STATS_EN
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt,
`endif
   output logic        halted,
   output logic        mem_err
);

   localparam logic [1:0] c_run      = 2'd0;
   localparam logic [1:0] c_mem_wait = 2'd1;
   localparam logic [1:0] c_halted   = 2'd2;
   localparam logic [7:0] c_timeout  = 8'(MEM_TIMEOUT);

   logic [1:0] r_state, w_next_state;
   logic [7:0] r_wait_cnt, w_next_wait_cnt;
   logic       r_mem_err, w_next_mem_err;
   logic       w_load_use, w_mem_stall;
   logic       w_en_pc, w_en_fd, w_en_dx, w_en_xm, w_en_mw, w_flush_fd, w_flush_dx;

   // R0 is hardwired zero, so a load targeting it can never create a hazard.
   assign w_load_use  = mem_read_dx && (rd_dx != 4'd0) &&
                        ((rd_dx == rs_fd) || (uses_rt_fd && (rd_dx == rt_fd)));
   assign w_mem_stall = mem_req_xm && !mem_ready;

   always_comb begin
      w_next_state    = r_state;
      w_next_wait_cnt = r_wait_cnt;
      w_next_mem_err  = r_mem_err;
      w_en_pc    = 1'b0;
      w_en_fd    = 1'b0;
      w_en_dx    = 1'b0;
      w_en_xm    = 1'b0;
      w_en_mw    = 1'b0;
      w_flush_fd = 1'b0;
      w_flush_dx = 1'b0;
      if (r_state != c_halted) begin
         if (hlt_mw) begin
            w_next_state = c_halted;
         end else if (w_mem_stall) begin
            if (r_state == c_run) begin
               w_next_state    = c_mem_wait;
               w_next_wait_cnt = 8'd1;
            end else if (r_wait_cnt == c_timeout) begin
               w_next_mem_err = 1'b1;
               w_next_state   = c_halted;
            end else begin
               w_next_wait_cnt = r_wait_cnt + 8'd1;
            end
         end else begin
            // Leaving a wait applies the normal hazard rules in the same cycle.
            w_next_state    = c_run;
            w_next_wait_cnt = 8'd0;
            w_en_dx = 1'b1;
            w_en_xm = 1'b1;
            w_en_mw = 1'b1;
            if (w_load_use) begin
               w_flush_dx = 1'b1;
            end else begin
               w_en_pc    = 1'b1;
               w_en_fd    = 1'b1;
               w_flush_fd = branch_taken_d;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= c_run;
         r_wait_cnt <= 8'd0;
         r_mem_err  <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_wait_cnt <= w_next_wait_cnt;
         r_mem_err  <= w_next_mem_err;
      end
   end

   assign en_pc    = rst & w_en_pc;
   assign en_fd    = rst & w_en_fd;
   assign en_dx    = rst & w_en_dx;
   assign en_xm    = rst & w_en_xm;
   assign en_mw    = rst & w_en_mw;
   assign flush_fd = rst & w_flush_fd;
   assign flush_dx = rst & w_flush_dx;
   assign halted   = (r_state == c_halted);
   assign mem_err  = r_mem_err;

`ifdef HAZARD_STATS_EN
   logic [15:0] r_stall_cnt, r_flush_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cnt <= 16'd0;
         r_flush_cnt <= 16'd0;
      end else begin
         if ((r_state != c_halted) && !w_en_pc && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
         if ((w_flush_fd || w_flush_dx) && (r_flush_cnt != 16'hFFFF))
            r_flush_cnt <= r_flush_cnt + 16'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire
